// File: rtl/uart_buffered_bridge.sv
// Byte bridge between the UART recv/trans cores and the CPU request/acknowledge ports.
// Independent RX/TX FIFOs, RX high-water hint and dropped-byte counter; UART_LOOPBACK_EN routes RX bytes into TX.
module uart_buffered_bridge #(
    parameter int RX_AW         = 10,
    parameter int TX_AW         = 10,
    parameter int RX_HIGH_WATER = 2**RX_AW - 16,
    parameter int LOST_CNT_W    = 16
) (
    input  logic                  clk,
`ifdef UART_LOOPBACK_EN
    input  logic                  loopback,
`endif
    input  logic                  reset,
    output logic                  recv_reset,
    input  logic [7:0]            recv_data,
    input  logic                  recv_ok,
    output logic                  trans_reset,
    output logic [7:0]            trans_data,
    output logic                  trans_ok,
    input  logic                  trans_busy,
    input  logic [7:0]            uart_in_data,
    input  logic                  uart_in_valid,
    output logic                  uart_in_ready,
    input  logic                  uart_out_valid,
    output logic [7:0]            uart_out_data,
    output logic                  uart_out_ready,
    output logic [RX_AW:0]        in_buffer_length,
    output logic [TX_AW:0]        out_buffer_length,
    output logic                  recv_hold,
    output logic                  lost,
    output logic [LOST_CNT_W-1:0] lost_count,
    input  logic                  clear_lost
);

    localparam logic [RX_AW:0] C_RX_HW = (RX_AW+1)'(RX_HIGH_WATER);

    logic [7:0]            r_rx_mem [2**RX_AW];
    logic [7:0]            r_tx_mem [2**TX_AW];
    logic [RX_AW:0]        r_rx_head, r_rx_tail;
    logic [TX_AW:0]        r_tx_head, r_tx_tail;
    logic                  r_out_ready, r_in_ready, r_trans_ok, r_guard, r_recv_hold, r_lost;
    logic [7:0]            r_out_data, r_trans_data;
    logic [LOST_CNT_W-1:0] r_lost_count;

    logic                  w_loop;
    logic                  w_rx_empty, w_rx_full, w_tx_empty, w_tx_full;
    logic                  w_rx_push, w_rx_pop, w_tx_cpu_push, w_tx_lb_push, w_tx_push, w_tx_pop, w_drop;
    logic [7:0]            w_tx_wdata;
    logic [RX_AW:0]        w_rx_head_nx, w_rx_tail_nx, w_rx_len_nx;
    logic [TX_AW:0]        w_tx_head_nx, w_tx_tail_nx;

`ifdef UART_LOOPBACK_EN
    assign w_loop = loopback;
`else
    assign w_loop = 1'b0;
`endif

    // Full/empty come only from the pointers registered before this edge.
    assign w_rx_empty = (r_rx_head == r_rx_tail);
    assign w_rx_full  = (r_rx_head[RX_AW-1:0] == r_rx_tail[RX_AW-1:0]) && (r_rx_head[RX_AW] != r_rx_tail[RX_AW]);
    assign w_tx_empty = (r_tx_head == r_tx_tail);
    assign w_tx_full  = (r_tx_head[TX_AW-1:0] == r_tx_tail[TX_AW-1:0]) && (r_tx_head[TX_AW] != r_tx_tail[TX_AW]);

    assign w_rx_push     = recv_ok && !w_loop && !w_rx_full;
    assign w_rx_pop      = uart_out_valid && !r_out_ready && !w_rx_empty;
    assign w_tx_cpu_push = uart_in_valid && !r_in_ready && !w_tx_full;
    assign w_tx_lb_push  = recv_ok && w_loop && !w_tx_full && !w_tx_cpu_push;
    assign w_tx_push     = w_tx_cpu_push || w_tx_lb_push;
    assign w_tx_wdata    = w_tx_cpu_push ? uart_in_data : recv_data;
    assign w_tx_pop      = !trans_busy && !w_tx_empty && !r_guard;
    assign w_drop        = recv_ok && (w_loop ? (w_tx_full || w_tx_cpu_push) : w_rx_full);

    assign w_rx_tail_nx = r_rx_tail + {{RX_AW{1'b0}}, w_rx_push};
    assign w_rx_head_nx = r_rx_head + {{RX_AW{1'b0}}, w_rx_pop};
    assign w_tx_tail_nx = r_tx_tail + {{TX_AW{1'b0}}, w_tx_push};
    assign w_tx_head_nx = r_tx_head + {{TX_AW{1'b0}}, w_tx_pop};
    assign w_rx_len_nx  = w_rx_tail_nx - w_rx_head_nx;

    // FIFO storage; contents survive reset, only the pointers are cleared.
    always_ff @(posedge clk) begin
        if (reset && w_rx_push) r_rx_mem[r_rx_tail[RX_AW-1:0]] <= recv_data;
        if (reset && w_tx_push) r_tx_mem[r_tx_tail[TX_AW-1:0]] <= w_tx_wdata;
    end

    // Pointers, acknowledges, launch strobe and the one-cycle launch guard.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rx_head    <= '0;
            r_rx_tail    <= '0;
            r_tx_head    <= '0;
            r_tx_tail    <= '0;
            r_out_ready  <= 1'b0;
            r_in_ready   <= 1'b0;
            r_trans_ok   <= 1'b0;
            r_guard      <= 1'b0;
            r_recv_hold  <= 1'b0;
            r_out_data   <= 8'h00;
            r_trans_data <= 8'h00;
        end else begin
            r_rx_head   <= w_rx_head_nx;
            r_rx_tail   <= w_rx_tail_nx;
            r_tx_head   <= w_tx_head_nx;
            r_tx_tail   <= w_tx_tail_nx;
            r_out_ready <= w_rx_pop;
            r_in_ready  <= w_tx_cpu_push;
            r_trans_ok  <= w_tx_pop;
            r_guard     <= w_tx_pop;
            r_recv_hold <= (w_rx_len_nx >= C_RX_HW);
            if (w_rx_pop) r_out_data   <= r_rx_mem[r_rx_head[RX_AW-1:0]];
            if (w_tx_pop) r_trans_data <= r_tx_mem[r_tx_head[TX_AW-1:0]];
        end
    end

    // Sticky drop flag and saturating counter; a same-cycle clear beats a drop.
    always_ff @(posedge clk) begin
        if (!reset || clear_lost) begin
            r_lost       <= 1'b0;
            r_lost_count <= '0;
        end else if (w_drop) begin
            r_lost <= 1'b1;
            if (r_lost_count != {LOST_CNT_W{1'b1}}) r_lost_count <= r_lost_count + LOST_CNT_W'(1);
        end
    end

    assign recv_reset        = !reset;
    assign trans_reset       = !reset;
    assign trans_data        = r_trans_data;
    assign trans_ok          = r_trans_ok;
    assign uart_in_ready     = r_in_ready;
    assign uart_out_data     = r_out_data;
    assign uart_out_ready    = r_out_ready;
    assign in_buffer_length  = r_rx_tail - r_rx_head;
    assign out_buffer_length = r_tx_tail - r_tx_head;
    assign recv_hold         = r_recv_hold;
    assign lost              = r_lost;
    assign lost_count        = r_lost_count;

endmodule

// File: tb/tb_uart_buffered_bridge.sv
// Directed self-checking bench for uart_buffered_bridge with 4-entry FIFOs and a 2-bit drop counter.
module tb_uart_buffered_bridge;
    localparam int RX_AW = 2;
    localparam int TX_AW = 2;
    localparam int HW    = 3;
    localparam int LW    = 2;

    logic          clk = 1'b0;
    logic          reset, recv_ok, trans_busy, uart_in_valid, uart_out_valid, clear_lost;
    logic [7:0]    recv_data, uart_in_data;
    logic          recv_reset, trans_reset, trans_ok, uart_in_ready, uart_out_ready, recv_hold, lost;
    logic [7:0]    trans_data, uart_out_data;
    logic [RX_AW:0] in_buffer_length;
    logic [TX_AW:0] out_buffer_length;
    logic [LW-1:0] lost_count;
`ifdef UART_LOOPBACK_EN
    logic          loopback;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int launch_cyc[$];
    logic [7:0] launch_dat[$];

    always #5 clk = ~clk;

    uart_buffered_bridge #(.RX_AW(RX_AW), .TX_AW(TX_AW), .RX_HIGH_WATER(HW), .LOST_CNT_W(LW)) dut (
        .clk(clk),
`ifdef UART_LOOPBACK_EN
        .loopback(loopback),
`endif
        .reset(reset), .recv_reset(recv_reset), .recv_data(recv_data), .recv_ok(recv_ok),
        .trans_reset(trans_reset), .trans_data(trans_data), .trans_ok(trans_ok), .trans_busy(trans_busy),
        .uart_in_data(uart_in_data), .uart_in_valid(uart_in_valid), .uart_in_ready(uart_in_ready),
        .uart_out_valid(uart_out_valid), .uart_out_data(uart_out_data), .uart_out_ready(uart_out_ready),
        .in_buffer_length(in_buffer_length), .out_buffer_length(out_buffer_length),
        .recv_hold(recv_hold), .lost(lost), .lost_count(lost_count), .clear_lost(clear_lost)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Record every transmit launch with its cycle stamp.
    always @(negedge clk) begin
        if (trans_ok === 1'b1) begin
            launch_cyc.push_back(cyc);
            launch_dat.push_back(trans_data);
        end
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic recv_byte(input logic [7:0] b);
        recv_data = b;
        recv_ok   = 1'b1;
        tick();
        recv_ok   = 1'b0;
    endtask

    task automatic cpu_read(input string tag, input logic [7:0] exp);
        logic got;
        got = 1'b0;
        uart_out_valid = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (uart_out_ready === 1'b1) begin
                got = 1'b1;
                check_value(tag, 32'(uart_out_data), 32'(exp));
            end
        end
        uart_out_valid = 1'b0;
        check_value({tag, "_ack"}, 32'(got), 32'd1);
        tick();
    endtask

    task automatic cpu_write(input string tag, input logic [7:0] b);
        logic got;
        got = 1'b0;
        uart_in_data  = b;
        uart_in_valid = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (uart_in_ready === 1'b1) got = 1'b1;
        end
        uart_in_valid = 1'b0;
        check_value({tag, "_ack"}, 32'(got), 32'd1);
    endtask

    task automatic check_launches(input string tag, input logic [7:0] exp_dat[$]);
        check_value({tag, "_count"}, 32'(launch_dat.size()), 32'(exp_dat.size()));
        for (int i = 0; i < exp_dat.size(); i++) begin
            check_value($sformatf("%s_data%0d", tag, i), 32'(launch_dat[i]), 32'(exp_dat[i]));
            if (i > 0) check_value($sformatf("%s_gap%0d", tag, i), 32'(launch_cyc[i] - launch_cyc[i-1]), 32'd2);
        end
    endtask

    initial begin
        int pulses;
        logic [7:0] exp_q[$];
        reset = 1'b0; recv_ok = 1'b0; trans_busy = 1'b0; uart_in_valid = 1'b0; uart_out_valid = 1'b0;
        clear_lost = 1'b0; recv_data = 8'h00; uart_in_data = 8'h00;
`ifdef UART_LOOPBACK_EN
        loopback = 1'b0;
`endif
        repeat (3) tick();
        reset = 1'b1;
        tick();

        // Reset mid-traffic
        recv_byte(8'h77);
        recv_byte(8'h88);
        cpu_read("pre_rd", 8'h77);
        cpu_write("pre_wr", 8'h99);
        repeat (3) tick();
        trans_busy = 1'b1;
        cpu_write("pre_wr2", 8'h9A);
        recv_data = 8'hEE; recv_ok = 1'b1; uart_out_valid = 1'b1;
        reset = 1'b0;
        #1;
        check_value("recv_reset_low", 32'(recv_reset), 32'd1);
        check_value("trans_reset_low", 32'(trans_reset), 32'd1);
        repeat (3) tick();
        check_value("rst_in_len", 32'(in_buffer_length), 32'd0);
        check_value("rst_out_len", 32'(out_buffer_length), 32'd0);
        check_value("rst_trans_ok", 32'(trans_ok), 32'd0);
        check_value("rst_out_ready", 32'(uart_out_ready), 32'd0);
        check_value("rst_in_ready", 32'(uart_in_ready), 32'd0);
        check_value("rst_lost", 32'(lost), 32'd0);
        check_value("rst_lost_count", 32'(lost_count), 32'd0);
        check_value("rst_hold", 32'(recv_hold), 32'd0);
        check_value("rst_trans_data", 32'(trans_data), 32'd0);
        check_value("rst_out_data", 32'(uart_out_data), 32'd0);
        recv_ok = 1'b0; uart_out_valid = 1'b0; trans_busy = 1'b0;
        reset = 1'b1;
        tick();
        check_value("recv_reset_high", 32'(recv_reset), 32'd0);
        check_value("post_rst_in_len", 32'(in_buffer_length), 32'd0);

        // RX overflow, high-water hint, read order
        recv_byte(8'h11);
        recv_byte(8'h22);
        check_value("hold_at_2", 32'(recv_hold), 32'd0);
        recv_byte(8'h33);
        check_value("hold_at_3", 32'(recv_hold), 32'd1);
        recv_byte(8'h44);
        check_value("lost_before_ovf", 32'(lost), 32'd0);
        recv_byte(8'h55);
        check_value("ovf_in_len", 32'(in_buffer_length), 32'd4);
        check_value("ovf_lost", 32'(lost), 32'd1);
        check_value("ovf_lost_count", 32'(lost_count), 32'd1);
        cpu_read("rd_11", 8'h11);
        check_value("hold_len3", 32'(recv_hold), 32'd1);
        cpu_read("rd_22", 8'h22);
        check_value("hold_len2", 32'(recv_hold), 32'd0);
        cpu_read("rd_33", 8'h33);
        cpu_read("rd_44", 8'h44);
        check_value("drained_len", 32'(in_buffer_length), 32'd0);
        pulses = 0;
        uart_out_valid = 1'b1;
        repeat (4) begin tick(); if (uart_out_ready === 1'b1) pulses++; end
        uart_out_valid = 1'b0;
        check_value("empty_read_pulses", 32'(pulses), 32'd0);

        // Counter saturation and clear-versus-drop priority
        for (int i = 0; i < 4; i++) recv_byte(8'hA0 + 8'(i));
        recv_byte(8'hF1);
        recv_byte(8'hF2);
        check_value("cnt_3", 32'(lost_count), 32'd3);
        recv_byte(8'hF3);
        check_value("cnt_sat", 32'(lost_count), 32'd3);
        clear_lost = 1'b1;
        recv_byte(8'hF4);
        clear_lost = 1'b0;
        check_value("clr_wins_lost", 32'(lost), 32'd0);
        check_value("clr_wins_cnt", 32'(lost_count), 32'd0);
        recv_byte(8'hF5);
        check_value("after_clr_cnt", 32'(lost_count), 32'd1);
        check_value("after_clr_lost", 32'(lost), 32'd1);
        for (int i = 0; i < 4; i++) cpu_read($sformatf("rd_a%0d", i), 8'hA0 + 8'(i));

        // Read request waiting on an empty RX
        uart_out_valid = 1'b1;
        pulses = 0;
        repeat (10) begin tick(); if (uart_out_ready === 1'b1) pulses++; end
        check_value("wait_no_pulse", 32'(pulses), 32'd0);
        recv_data = 8'hA5; recv_ok = 1'b1;
        tick();
        recv_ok = 1'b0;
        check_value("wait_ready_1st", 32'(uart_out_ready), 32'd0);
        tick();
        check_value("wait_ready_2nd", 32'(uart_out_ready), 32'd1);
        check_value("wait_data", 32'(uart_out_data), 32'hA5);
        repeat (5) begin tick(); if (uart_out_ready === 1'b1) pulses++; end
        uart_out_valid = 1'b0;
        check_value("wait_no_second", 32'(pulses), 32'd0);
        tick();

        // Simultaneous push and pop
        recv_byte(8'hB1);
        recv_byte(8'hB2);
        recv_data = 8'hB3; recv_ok = 1'b1; uart_out_valid = 1'b1;
        tick();
        recv_ok = 1'b0; uart_out_valid = 1'b0;
        check_value("pp_data", 32'(uart_out_data), 32'hB1);
        check_value("pp_len", 32'(in_buffer_length), 32'd2);
        tick();
        cpu_read("rd_b2", 8'hB2);
        cpu_read("rd_b3", 8'hB3);

        // Transmit with trans_busy low
        launch_cyc.delete(); launch_dat.delete();
        cpu_write("wr_01", 8'h01);
        cpu_write("wr_02", 8'h02);
        cpu_write("wr_03", 8'h03);
        repeat (10) tick();
        exp_q = '{8'h01, 8'h02, 8'h03};
        check_launches("txa", exp_q);
        check_value("txa_len", 32'(out_buffer_length), 32'd0);

        // Preloaded TX: full stall, then back-to-back launches held apart by the guard
        launch_cyc.delete(); launch_dat.delete();
        trans_busy = 1'b1;
        cpu_write("wr_10", 8'h10);
        cpu_write("wr_20", 8'h20);
        cpu_write("wr_30", 8'h30);
        cpu_write("wr_40", 8'h40);
        check_value("txb_full_len", 32'(out_buffer_length), 32'd4);
        pulses = 0;
        uart_in_data = 8'h50; uart_in_valid = 1'b1;
        repeat (4) begin tick(); if (uart_in_ready === 1'b1) pulses++; end
        check_value("txb_stall", 32'(pulses), 32'd0);
        check_value("txb_no_launch", 32'(launch_dat.size()), 32'd0);
        trans_busy = 1'b0;
        for (int i = 0; i < 20 && pulses == 0; i++) begin tick(); if (uart_in_ready === 1'b1) pulses++; end
        uart_in_valid = 1'b0;
        check_value("txb_stall_ack", 32'(pulses), 32'd1);
        repeat (15) tick();
        exp_q = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
        check_launches("txb", exp_q);
        check_value("txb_len", 32'(out_buffer_length), 32'd0);

`ifdef UART_LOOPBACK_EN
        launch_cyc.delete(); launch_dat.delete();
        loopback = 1'b1;
        recv_byte(8'h5A);
        repeat (5) tick();
        loopback = 1'b0;
        exp_q = '{8'h5A};
        check_launches("lb", exp_q);
        check_value("lb_in_len", 32'(in_buffer_length), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_buffered_bridge.md
Name: uart_buffered_bridge

Overview:
- Second-generation byte bridge between the UART receiver/transmitter cores and the CPU-side UART request/acknowledge interface.
- Independent, separately sized RX and TX FIFOs; true full-depth occupancy; programmable RX high-water flow-control hint; saturating dropped-byte counter.
- A one-cycle guard after each transmit launch covers the transmitter's one-cycle busy latency.
- Sits between the recv/trans cores and the core's uart_in/uart_out ports.

Parameters:
- RX_AW, 10, log2 of RX FIFO depth; depth is 2**RX_AW entries, all usable.
- TX_AW, 10, log2 of TX FIFO depth; depth is 2**TX_AW entries, all usable.
- RX_HIGH_WATER, 2**RX_AW-16, RX occupancy at or above which recv_hold asserts; legal range 1..2**RX_AW.
- LOST_CNT_W, 16, width of the dropped-byte counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset (0 = reset asserted)
- recv_reset  out  1  active-high reset to the receiver core; combinationally equal to !reset
- recv_data  in  8  received byte
- recv_ok  in  1  one-cycle strobe: recv_data is valid
- trans_reset  out  1  active-high reset to the transmitter core; equal to !reset
- trans_data  out  8  byte to transmit
- trans_ok  out  1  one-cycle launch strobe to the transmitter
- trans_busy  in  1  transmitter busy
- uart_in_data  in  8  byte from the CPU to send
- uart_in_valid  in  1  CPU write request, held until acknowledged
- uart_in_ready  out  1  one-cycle write acknowledge
- uart_out_valid  in  1  CPU read request, held until acknowledged
- uart_out_data  out  8  read byte, valid while uart_out_ready=1
- uart_out_ready  out  1  one-cycle read acknowledge
- in_buffer_length  out  RX_AW+1  RX occupancy, 0..2**RX_AW
- out_buffer_length  out  TX_AW+1  TX occupancy, 0..2**TX_AW
- recv_hold  out  1  registered; 1 when RX occupancy >= RX_HIGH_WATER
- lost  out  1  sticky: at least one RX byte has been dropped
- lost_count  out  LOST_CNT_W  saturating count of dropped RX bytes
- clear_lost  in  1  one-cycle pulse; clears lost and lost_count

Behaviour:
- Reset (reset=0 at a clk edge):
  - All pointers are zeroed, so both lengths read 0.
  - trans_ok, uart_in_ready, uart_out_ready, recv_hold, lost and lost_count are 0. trans_data and uart_out_data are 0.
  - The TX guard flag is cleared. FIFO contents are not cleared.
  - Reset mid-operation abandons any byte in flight.
- FIFO pointers:
  - Each FIFO keeps head and tail pointers of AW+1 bits that wrap naturally.
  - empty is head==tail.
  - full is when the low AW bits are equal and the MSBs differ.
  - length is tail-head, modulo 2**(AW+1).
- Decision timing: every push and pop decision uses the full/empty state registered before the edge.
  - A push while full is refused even if a pop happens in the same cycle.
  - A pop while empty waits, even if a push happens in the same cycle.
  - A simultaneous push and pop leaves the length unchanged.
- RX push: on recv_ok with RX not full, store recv_data at the tail and increment the tail.
- RX overflow: on recv_ok with RX full, drop the byte and set lost=1.
  - lost_count increments and saturates at all-ones.
  - If clear_lost and an overflow occur in the same cycle, the clear wins and the drop is not counted.
- CPU read (two-cycle request/acknowledge):
  - If uart_out_valid=1, uart_out_ready=0 and RX is not empty: register uart_out_data from the RX head, increment the head, and pulse uart_out_ready=1 for exactly one cycle.
  - Otherwise uart_out_ready=0.
  - With valid held high, acknowledges therefore come at most every other cycle.
- CPU write:
  - If uart_in_valid=1, uart_in_ready=0 and TX is not full: write uart_in_data at the TX tail, increment the tail, and pulse uart_in_ready for one cycle.
  - With TX full, the request stalls until space frees.
- TX launch:
  - If trans_busy=0, TX is not empty and guard=0: register trans_data from the TX head, increment the head, pulse trans_ok for one cycle, and set guard=1.
  - guard clears on the next cycle, so consecutive launches are at least 2 cycles apart even if trans_busy stays 0.
- recv_hold is registered from the next-state RX occupancy, so it tracks the length with zero added lag.

Optional Feature:
- Macro: UART_LOOPBACK_EN.
- Defined:
  - Adds input port loopback (1 bit).
  - While loopback=1, recv_ok bytes are pushed into the TX FIFO instead of the RX FIFO. If TX is full the byte is dropped and counted in lost/lost_count.
  - A CPU write takes priority over a loopback push in the same cycle; the loopback byte is then dropped and counted.
  - The CPU read path is unaffected.
- Not defined: no loopback port; behaviour is exactly as described above.

Test Plan:
- Reset held low 3 cycles mid-traffic -> lengths 0; trans_ok=0, uart_out_ready=0, lost=0, lost_count=0; recv_reset=1 while reset=0.
- RX_AW=2: 5 recv_ok bytes 0x11..0x55 -> in_buffer_length=4; lost=1, lost_count=1; reads return 0x11,0x22,0x33,0x44; 0x55 is never returned.
- uart_out_valid held high with RX empty; at cycle 10, recv_ok delivers 0xA5 -> uart_out_ready pulses once with uart_out_data=0xA5 two cycles later; no second pulse.
- trans_busy tied 0; CPU writes 0x01,0x02,0x03 -> trans_ok pulses with 0x01,0x02,0x03 spaced exactly 2 cycles apart; out_buffer_length returns to 0.
- RX_AW=3, RX_HIGH_WATER=6: push 6 bytes -> recv_hold=1 on the cycle after the 6th recv_ok; one read -> recv_hold=0.
- With UART_LOOPBACK_EN defined and loopback=1: recv 0x5A -> trans_ok with trans_data=0x5A; in_buffer_length stays 0.
